// File: rtl/uart_tx_sched.sv
// uart_tx_sched: moves bytes from a show-ahead TX FIFO to a UART transmitter with CTS flow control, inter-byte gap and flush
module uart_tx_sched #(
  parameter int BW      = 8,
  parameter int FLEN    = 8,
  parameter int GAP_CYC = 2,
  parameter int LOWMARK = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic          i_cts_n,
  input  logic          i_fifo_empty,
  input  logic [FLEN:0] i_fifo_fill,
  input  logic [BW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  input  logic          i_tx_busy,
  output logic          o_tx_stb,
  output logic [BW-1:0] o_tx_data,
  output logic          o_busy,
  output logic          o_txlow,
  output logic [15:0]   o_tx_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FLUSH} state_t;
  localparam logic [7:0]    GAP_LD = 8'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [FLEN:0] LOW    = (FLEN+1)'(LOWMARK);
  state_t     state;
  logic [7:0] gap_cnt;
  logic       start, xfer;
  assign start     = state == IDLE && i_enable && !i_fifo_empty && !i_cts_n && !i_flush;
  assign xfer      = o_tx_stb && !i_tx_busy;
  // Pop is suppressed while held in reset so a start cannot steal a byte before the first live edge.
  assign o_fifo_rd = i_rst_n && (start || (state == FLUSH && !i_fifo_empty));
  assign o_busy    = state != IDLE;
  // Scheduler FSM with registered strobe, data, byte counter, gap timer and low-watermark flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_tx_stb   <= 1'b0;
      o_tx_data  <= '0;
      o_tx_count <= '0;
      gap_cnt    <= '0;
      o_txlow    <= 1'b1;
    end else begin
      o_txlow <= i_fifo_fill < LOW;
      case (state)
        IDLE:
          if (i_flush) state <= FLUSH;
          else if (start) begin
            o_tx_data <= i_fifo_data;
            o_tx_stb  <= 1'b1;
            state     <= SEND;
          end
        SEND:
          if (xfer) begin
            o_tx_count <= o_tx_count + 16'd1;
            o_tx_stb   <= 1'b0;
            gap_cnt    <= GAP_LD;
            state      <= i_flush ? FLUSH : (GAP_CYC > 0 ? GAP : IDLE);
          end else if (i_flush) begin
            o_tx_stb <= 1'b0;
            state    <= FLUSH;
          end
        GAP:
          if (i_flush) begin
            gap_cnt <= '0;
            state   <= FLUSH;
          end else if (gap_cnt == 8'd0) state <= IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        FLUSH:
          if (i_fifo_empty && !i_flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter BW, default 8, the data bits per FIFO element and per UART byte.
REQ-002 SHALL have parameter FLEN, default 8, the FIFO address width; fill-level width is FLEN+1.
REQ-003 SHALL have parameter GAP_CYC, default 2, the idle cycles inserted after each accepted byte (range 0..255).
REQ-004 SHALL have parameter LOWMARK, default 4, the fill level below which the low-watermark flag is set.
REQ-005 SHALL have i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have i_enable  input  1  scheduler enabled; 0 blocks new starts only.
REQ-008 SHALL have i_flush  input  1  discard queued FIFO contents.
REQ-009 SHALL have i_cts_n  input  1  clear-to-send, active-low, sampled only at byte start.
REQ-010 SHALL have i_fifo_empty  input  1  TX FIFO empty flag.
REQ-011 SHALL have i_fifo_fill  input  FLEN+1  TX FIFO occupancy.
REQ-012 SHALL have i_fifo_data  input  BW  TX FIFO show-ahead head element.
REQ-013 SHALL have o_fifo_rd  output  1  FIFO pop, combinational, pops on the same rising edge.
REQ-014 SHALL have i_tx_busy  input  1  UART transmitter busy.
REQ-015 SHALL have o_tx_stb  output  1  byte valid to transmitter.
REQ-016 SHALL have o_tx_data  output  BW  byte to transmitter.
REQ-017 SHALL have o_busy  output  1  state not IDLE.
REQ-018 SHALL have o_txlow  output  1  registered low-watermark flag.
REQ-019 SHALL have o_tx_count  output  16  count of bytes accepted by the transmitter.

Function
REQ-020 SHALL implement states IDLE, SEND, GAP, FLUSH.
REQ-021 IDLE: i_flush=1 SHALL go to FLUSH (flush takes priority over start).
REQ-022 IDLE: i_enable=1, i_fifo_empty=0, i_cts_n=0, i_flush=0 SHALL assert o_fifo_rd that cycle, load o_tx_data from i_fifo_data on that edge, and enter SEND.
REQ-023 SEND: o_tx_stb SHALL be 1 and o_tx_data SHALL stay stable until transfer.
REQ-024 Transfer SHALL occur on any edge where o_tx_stb=1 and i_tx_busy=0; o_tx_count increments by 1 modulo 2^16.
REQ-025 On transfer: i_flush=1 SHALL go to FLUSH, else GAP_CYC>0 SHALL go to GAP, else IDLE.
REQ-026 SEND with i_flush=1 and no transfer that cycle SHALL drop o_tx_stb next cycle, discard the byte (no count), and enter FLUSH.
REQ-027 GAP SHALL last exactly GAP_CYC cycles, then enter IDLE; i_flush=1 during GAP SHALL enter FLUSH immediately.
REQ-028 FLUSH: o_fifo_rd SHALL equal !i_fifo_empty each cycle; exit to IDLE when i_fifo_empty=1 and i_flush=0.
REQ-029 o_fifo_rd SHALL never assert while i_fifo_empty=1, nor outside the cases of REQ-022 and REQ-028.
REQ-030 Deasserting i_enable or raising i_cts_n mid-byte SHALL NOT withdraw o_tx_stb.
REQ-031 Minimum byte-to-byte start spacing with i_tx_busy=0 SHALL be GAP_CYC+2 cycles.
REQ-032 o_txlow SHALL register (i_fifo_fill < LOWMARK) every cycle.
REQ-033 o_busy SHALL be combinational (state != IDLE).

Reset
REQ-034 i_rst_n=0 SHALL immediately force state IDLE, o_tx_stb=0, o_tx_data=0, o_tx_count=0, gap counter=0, o_txlow=1, independent of i_clk.
REQ-035 Reset during SEND SHALL abandon the byte without a pop beyond the one already taken.
REQ-036 First start SHALL be possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-037 Fill 3 bytes 0x41,0x42,0x43, enable, cts_n=0, busy=0 -> three transfers, in order, starts exactly 4 cycles apart, o_tx_count=3.
REQ-038 Hold i_tx_busy=1 for 10 cycles in SEND -> o_tx_stb and o_tx_data held stable 10 cycles, transfer on first busy=0 edge.
REQ-039 i_cts_n=1 with FIFO non-empty -> no o_fifo_rd, o_tx_stb=0; release cts_n -> start next cycle.
REQ-040 5 bytes queued, pulse i_flush during SEND with busy=1 -> stb drops, FIFO drains to empty one pop per cycle, o_tx_count unchanged.
REQ-041 Fill 0->5->3 with LOWMARK=4 -> o_txlow 1, 0, 1, each one cycle after the fill change.
REQ-042 Assert i_rst_n=0 mid-SEND between edges -> outputs reach reset values before the next edge.
